// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: erase / convert / readout sequencing for one single-slope frame.
// Latched gray codes are converted to binary and streamed out over valid/ready.
module adc_conv_sequencer #(
  parameter int CNT_W     = 8,
  parameter int NUM_PIX   = 4,
  parameter int IDX_W     = 2,
  parameter int ERASE_CYC = 5,
  parameter int CONV_CYC  = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             erase,
  output logic             convert,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_sel,
  input  logic [CNT_W-1:0] pix_gray,
  output logic [CNT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  // state     | meaning
  // IDLE      | waiting for start
  // ERASE     | erase strobe held for ERASE_CYC cycles
  // CONVERT   | gray counter enabled for CONV_CYC cycles
  // READ      | rd_en pulse for pixel idx
  // WAIT      | pix_gray valid, captured and converted to binary
  // PRESENT   | result on out_data until handshake
  // DONE      | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE, ERASE, CONVERT, READ, WAIT, PRESENT, DONE
  } state_t;

  localparam int TMR_MAX = (ERASE_CYC > CONV_CYC) ? ERASE_CYC : CONV_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ERASE_LOAD = TMR_W'(ERASE_CYC - 1);
  localparam logic [TMR_W-1:0] CONV_LOAD  = TMR_W'(CONV_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PIX - 1);

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               busy_nxt, erase_nxt, convert_nxt, rd_en_nxt, out_valid_nxt, done_nxt;
  logic [IDX_W-1:0]   rd_sel_nxt, out_idx_nxt;
  logic [CNT_W-1:0]   out_data_nxt;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int i = CNT_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    idx_nxt      = idx;
    rd_sel_nxt   = rd_sel;
    out_idx_nxt  = out_idx;
    out_data_nxt = out_data;
    if (abort) begin
      state_nxt    = IDLE;
      tmr_nxt      = '0;
      idx_nxt      = '0;
      rd_sel_nxt   = '0;
      out_idx_nxt  = '0;
      out_data_nxt = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nxt = ERASE;
          tmr_nxt   = ERASE_LOAD;
        end
        ERASE: if (tmr == '0) begin
          state_nxt = CONVERT;
          tmr_nxt   = CONV_LOAD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
        CONVERT: if (tmr == '0) begin
          state_nxt = READ;
          idx_nxt   = '0;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
        READ: state_nxt = WAIT;
        WAIT: begin
          state_nxt    = PRESENT;
          out_data_nxt = gray2bin(pix_gray);
          out_idx_nxt  = idx;
        end
        PRESENT: if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
            idx_nxt   = idx + 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    // outputs are decoded from the next state so they leave the flops aligned with it
    busy_nxt      = (state_nxt != IDLE);
    erase_nxt     = (state_nxt == ERASE);
    convert_nxt   = (state_nxt == CONVERT);
    rd_en_nxt     = (state_nxt == READ);
    out_valid_nxt = (state_nxt == PRESENT);
    done_nxt      = (state_nxt == DONE);
    if (state_nxt == READ) rd_sel_nxt = idx_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmr       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      erase     <= 1'b0;
      convert   <= 1'b0;
      rd_en     <= 1'b0;
      rd_sel    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      erase     <= erase_nxt;
      convert   <= convert_nxt;
      rd_en     <= rd_en_nxt;
      rd_sel    <= rd_sel_nxt;
      out_data  <= out_data_nxt;
      out_idx   <= out_idx_nxt;
      out_valid <= out_valid_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: directed frames, expected results queued at stimulus time
// and checked by an independent output monitor.
module tb_adc_conv_sequencer;
  localparam int CNT_W   = 8;
  localparam int NUM_PIX = 4;
  localparam int IDX_W   = 2;
  localparam int W_DONE = 0, W_VALID = 1, W_RD = 2, W_ERASE = 3, W_CONV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic busy, erase, convert, rd_en, out_valid, done;
  logic [IDX_W-1:0] rd_sel, out_idx;
  logic [CNT_W-1:0] pix_gray, out_data;
  logic [CNT_W-1:0] pix_mem [NUM_PIX];
  int cyc;
  int n_chk = 0, n_err = 0, rd_cnt = 0, done_cnt = 0;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  adc_conv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .erase(erase), .convert(convert),
    .rd_en(rd_en), .rd_sel(rd_sel), .pix_gray(pix_gray),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;
  // pixel array readout mux: code appears one cycle after rd_en
  always_ff @(posedge clk) if (rd_en) pix_gray <= pix_mem[rd_sel];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_erase"},     int'(erase), 0);
    chk({tag, "_convert"},   int'(convert), 0);
    chk({tag, "_rd_en"},     int'(rd_en), 0);
    chk({tag, "_rd_sel"},    int'(rd_sel), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_idx"},   int'(out_idx), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_done"},      int'(done), 0);
  endtask

  function automatic bit cond(input int which, input int arg);
    case (which)
      W_DONE:  return done === 1'b1;
      W_VALID: return out_valid === 1'b1 && int'(out_idx) == arg;
      W_RD:    return rd_en === 1'b1 && int'(rd_sel) == arg;
      W_ERASE: return erase === 1'b1;
      default: return convert === 1'b1;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int which, input int arg, input int limit);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      hit = cond(which, arg);
      n++;
    end
    chk(name, int'(hit), 1);
  endtask

  // pg/eb pack pixel 0 in the low byte
  task automatic push_frame(input logic [31:0] pg, input logic [31:0] eb);
    exp_t e;
    for (int i = 0; i < NUM_PIX; i++) begin
      pix_mem[i] = pg[8*i +: 8];
      e.idx  = IDX_W'(i);
      e.data = eb[8*i +: 8];
      sb.push_back(e);
    end
  endtask

  task automatic do_frame(input string tag, input logic [31:0] pg, input logic [31:0] eb);
    int t0, ecnt, ccnt;
    push_frame(pg, eb);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    wait_cond({tag, "_erase_rise"}, W_ERASE, 0, 10);
    ecnt = 0;
    while (erase && ecnt < 400) begin ecnt++; @(negedge clk); end
    chk({tag, "_erase_len"}, ecnt, 5);
    chk({tag, "_conv_no_gap"}, int'(convert), 1);
    ccnt = 0;
    while (convert && ccnt < 400) begin ccnt++; @(negedge clk); end
    chk({tag, "_conv_len"}, ccnt, 255);
    wait_cond({tag, "_done"}, W_DONE, 0, 100);
    chk({tag, "_latency"}, cyc - t0, 273);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin : monitor
    logic prev_valid, prev_hs;
    logic [CNT_W-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;
    exp_t e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_hs) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_data",  int'(out_data), int'(prev_data));
          chk("hold_idx",   int'(out_idx), int'(prev_idx));
        end
        if (out_valid) chk("no_rd_while_valid", int'(rd_en), 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_data", int'(out_data), int'(e.data));
            chk("out_idx",  int'(out_idx), int'(e.idx));
          end
        end
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
      end
    end
  end

  initial begin : pulse_count
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1) rd_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d required finish before 20000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int rd0, d0, t1, t2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1 reset = 1'b0;

    // gray 80 everywhere converts to FF
    @(posedge clk); #1;
    do_frame("t1", 32'h80808080, 32'hFFFFFFFF);

    @(posedge clk); #1;
    do_frame("t2", 32'hC0030100, 32'h80020100);

    // back-pressure on pixel 1
    @(posedge clk); #1;
    push_frame(32'h44332211, 32'h78223C1E);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_cond("t3_rd1", W_RD, 1, 400);
    @(posedge clk); #1 out_ready = 1'b0;
    wait_cond("t3_valid1", W_VALID, 1, 10);
    rd0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("t3_still_valid", int'(out_valid), 1);
    chk("t3_no_rd_in_stall", rd_cnt - rd0, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_cond("t3_done", W_DONE, 0, 50);
    chk("t3_sb_drained", sb.size(), 0);

    // abort on convert cycle 100
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_cond("t4_conv", W_CONV, 0, 20);
    repeat (99) @(posedge clk);
    #1 abort = 1'b1;
    rd0 = rd_cnt;
    d0  = done_cnt;
    @(posedge clk); #1 abort = 1'b0;
    chk_idle("t4_abort");
    repeat (300) @(negedge clk);
    chk("t4_no_rd", rd_cnt - rd0, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_stays_idle", int'(busy), 0);
    @(posedge clk); #1;
    do_frame("t4_after", 32'h00000080, 32'h000000FF);

    // async reset while a result is presented
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_frame(32'h55555555, 32'h66666666);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_cond("t5_present", W_VALID, 0, 400);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk_idle("t5_reset");
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_frame("t5_after", 32'h01030C0F, 32'h0102080A);

    // start held high: back-to-back frames with one IDLE cycle between
    @(posedge clk); #1;
    push_frame(32'hFF804020, 32'hAAFF7F3F);
    push_frame(32'hFF804020, 32'hAAFF7F3F);
    start = 1'b1;
    wait_cond("t6_done1", W_DONE, 0, 400);
    t1 = cyc;
    @(negedge clk);
    chk("t6_gap_idle", int'(busy), 0);
    @(negedge clk);
    chk("t6_restart", int'(erase), 1);
    @(posedge clk); #1 start = 1'b0;
    wait_cond("t6_done2", W_DONE, 0, 400);
    t2 = cyc;
    chk("t6_period", t2 - t1, 274);
    repeat (5) @(negedge clk);
    chk("t6_stopped", int'(busy), 0);
    chk("t6_sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
